// File: rtl/game_state_fsm_pkg.sv
// Shared definitions for the game sequencer: display-facing State codes,
// BCD digit width, internal FSM states and small helper functions.
package game_state_fsm_pkg;

  // Encodings seen by the LED and display stages.
  localparam logic [1:0] SMENU = 2'd0;
  localparam logic [1:0] SGAME = 2'd1;
  localparam logic [1:0] SOVER = 2'd2;

  // Width of one BCD digit.
  localparam int BCD_W = 4;

  typedef enum logic [2:0] {
    ST_MENU,
    ST_INIT,
    ST_PLAY,
    ST_CHECK,
    ST_OVER
  } state_t;

  // Collapse internal states onto the three externally visible codes.
  function automatic logic [1:0] state_code(input state_t s);
    case (s)
      ST_MENU:                    return SMENU;
      ST_INIT, ST_PLAY, ST_CHECK: return SGAME;
      ST_OVER:                    return SOVER;
      default:                    return SMENU;
    endcase
  endfunction

  // Two-digit BCD of a value in 0..99.
  function automatic logic [2*BCD_W-1:0] bin2bcd2(input int unsigned v);
    return {BCD_W'(v / 10), BCD_W'(v % 10)};
  endfunction

endpackage

// File: rtl/game_state_fsm_if.sv
// Button, handshake and display signals of the game sequencer.
// master: the sequencer itself; slave: the surrounding board/checker/display.
interface game_state_fsm_if;
  logic        start_pulse;
  logic        submit_pulse;
  logic        abort_pulse;
  logic        init_done;
  logic        chk_done;
  logic        chk_ok;
  logic        init_req;
  logic        chk_req;
  logic [1:0]  State;
  logic        win;
  logic [15:0] time_bcd;

  modport master (
    input  start_pulse, submit_pulse, abort_pulse, init_done, chk_done, chk_ok,
    output init_req, chk_req, State, win, time_bcd
  );

  modport slave (
    output start_pulse, submit_pulse, abort_pulse, init_done, chk_done, chk_ok,
    input  init_req, chk_req, State, win, time_bcd
  );
endinterface

// File: rtl/game_state_fsm_timer.sv
// bcd_mmss_timer: saturating BCD mm:ss counter. Clear wins over a tick;
// a tick advances one second with the carry rippling in the same cycle;
// 99:59 holds.
import game_state_fsm_pkg::*;

module bcd_mmss_timer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        enable,
  input  logic        tick,
  output logic [15:0] time_bcd
);

  localparam logic [15:0] SAT = 16'h9959;

  logic [15:0]      time_reg, time_next;
  logic [BCD_W-1:0] sec_ones, sec_tens, min_ones, min_tens;

  assign sec_ones = time_reg[3:0];
  assign sec_tens = time_reg[7:4];
  assign min_ones = time_reg[11:8];
  assign min_tens = time_reg[15:12];

  // Next count: clear, hold, or one-second increment with digit carries.
  always_comb begin
    time_next = time_reg;
    if (clear) begin
      time_next = '0;
    end else if (enable && tick && time_reg != SAT) begin
      if (sec_ones != 4'd9) begin
        time_next[3:0] = sec_ones + 4'd1;
      end else begin
        time_next[3:0] = 4'd0;
        if (sec_tens != 4'd5) begin
          time_next[7:4] = sec_tens + 4'd1;
        end else begin
          time_next[7:4] = 4'd0;
          if (min_ones != 4'd9) begin
            time_next[11:8] = min_ones + 4'd1;
          end else begin
            time_next[11:8]  = 4'd0;
            time_next[15:12] = min_tens + 4'd1;
          end
        end
      end
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) time_reg <= '0;
    else        time_reg <= time_next;
  end

  assign time_bcd = time_reg;

endmodule

// File: rtl/game_state_fsm.sv
// game_state_fsm: game sequencer (menu / init / play / check / over) with a
// one-second prescaler feeding a BCD mm:ss play timer.
// Optional macro GAME_TIMEOUT_EN: ends the game (win=0) when the timer
// reaches TIME_LIMIT_M:00 while playing or checking.
import game_state_fsm_pkg::*;

module game_state_fsm #(
  parameter int unsigned TICK_DIV     = 100_000_000,
  parameter int unsigned TIME_LIMIT_M = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  game_state_fsm_if.master gs
);

  localparam int PS_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

`ifdef GAME_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  // Timer value one second before the limit; a tick from here lands on M:00.
  localparam logic [15:0] LIMIT_PRE = {bin2bcd2(TIME_LIMIT_M - 1), 8'h59};

  state_t          state_reg, state_next;
  logic [PS_W-1:0] ps_reg, ps_next;
  logic            init_req_reg, init_req_next;
  logic            chk_req_reg, chk_req_next;
  logic            win_reg, win_next;
  logic [1:0]      code_reg;
  logic            running, tick, timeout, timer_clear;
  logic [15:0]     time_w;

  assign running = (state_reg == ST_PLAY) || (state_reg == ST_CHECK);
  assign tick    = running && (ps_reg == PS_W'(TICK_DIV - 1));
  assign timeout = TIMEOUT_ON && tick && (time_w == LIMIT_PRE);

  // Next state and request/verdict registers; abort dominates everything.
  always_comb begin
    state_next    = state_reg;
    init_req_next = init_req_reg;
    chk_req_next  = chk_req_reg;
    win_next      = win_reg;
    timer_clear   = 1'b0;
    if (gs.abort_pulse && state_reg != ST_MENU) begin
      state_next    = ST_MENU;
      init_req_next = 1'b0;
      chk_req_next  = 1'b0;
      win_next      = 1'b0;
      timer_clear   = 1'b1;
    end else begin
      case (state_reg)
        ST_MENU: if (gs.start_pulse) begin
          state_next    = ST_INIT;
          init_req_next = 1'b1;
          timer_clear   = 1'b1;
        end
        ST_INIT: if (gs.init_done) begin
          state_next    = ST_PLAY;
          init_req_next = 1'b0;
        end
        ST_PLAY: if (timeout) begin
          state_next = ST_OVER;
          win_next   = 1'b0;
        end else if (gs.submit_pulse) begin
          state_next   = ST_CHECK;
          chk_req_next = 1'b1;
        end
        ST_CHECK: if (gs.chk_done) begin
          chk_req_next = 1'b0;
          if (gs.chk_ok) begin
            state_next = ST_OVER;
            win_next   = 1'b1;
          end else begin
            state_next = ST_PLAY;
          end
        end else if (timeout) begin
          state_next   = ST_OVER;
          chk_req_next = 1'b0;
          win_next     = 1'b0;
        end
        ST_OVER: if (gs.start_pulse) begin
          state_next = ST_MENU;
          win_next   = 1'b0;
        end
        default: state_next = ST_MENU;
      endcase
    end
  end

  // Prescaler: free-runs only while the game clock is live, wraps on the tick.
  always_comb begin
    ps_next = ps_reg;
    if (timer_clear)  ps_next = '0;
    else if (tick)    ps_next = '0;
    else if (running) ps_next = ps_reg + 1'b1;
  end

  // State, prescaler and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_MENU;
      ps_reg       <= '0;
      init_req_reg <= 1'b0;
      chk_req_reg  <= 1'b0;
      win_reg      <= 1'b0;
      code_reg     <= SMENU;
    end else begin
      state_reg    <= state_next;
      ps_reg       <= ps_next;
      init_req_reg <= init_req_next;
      chk_req_reg  <= chk_req_next;
      win_reg      <= win_next;
      code_reg     <= state_code(state_next);
    end
  end

  bcd_mmss_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (timer_clear),
    .enable   (running),
    .tick     (tick),
    .time_bcd (time_w)
  );

  assign gs.init_req = init_req_reg;
  assign gs.chk_req  = chk_req_reg;
  assign gs.win      = win_reg;
  assign gs.State    = code_reg;
  assign gs.time_bcd = time_w;

endmodule

// File: tb/tb_game_state_fsm.sv
// Directed bench for game_state_fsm (TICK_DIV=4, TIME_LIMIT_M=1). Expected
// output snapshots {State, win, init_req, chk_req, time_bcd} are queued as
// each step is driven and popped/compared once the DUT has responded.
module tb_game_state_fsm;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    string       tag;
    logic [20:0] exp;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  game_state_fsm_if bus();

  game_state_fsm #(.TICK_DIV(4), .TIME_LIMIT_M(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .gs    (bus.master)
  );

  // Advance one clock; inputs driven now are sampled at this edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clr_in();
    bus.start_pulse  = 1'b0;
    bus.submit_pulse = 1'b0;
    bus.abort_pulse  = 1'b0;
    bus.init_done    = 1'b0;
    bus.chk_done     = 1'b0;
    bus.chk_ok       = 1'b0;
  endtask

  task automatic push(input string tag, input logic [1:0] st, input logic w,
                      input logic ir, input logic cr, input logic [15:0] t);
    exp_t e;
    e.tag = tag;
    e.exp = {st, w, ir, cr, t};
    sb_q.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [20:0] obs;
    e   = sb_q.pop_front();
    obs = {bus.State, bus.win, bus.init_req, bus.chk_req, bus.time_bcd};
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    end
    $display("step %-14s obs=%h exp=%h", e.tag, obs, e.exp);
  endtask

  initial begin
    clr_in();
    // Reset
    push("reset", 2'd0, 0, 0, 0, 16'h0000);
    run(2);
    check();
    rst_n = 1'b1;
    cyc();

    // Start, init_done three cycles later
    bus.start_pulse = 1'b1;
    push("start", 2'd1, 0, 1, 0, 16'h0000);
    cyc(); clr_in(); check();
    push("init_hold", 2'd1, 0, 1, 0, 16'h0000);
    run(2); check();
    bus.init_done = 1'b1;
    push("play_entry", 2'd1, 0, 0, 0, 16'h0000);
    cyc(); clr_in(); check();

    // 40 cycles of play -> 10 seconds
    push("play_40", 2'd1, 0, 0, 0, 16'h0010);
    run(40); check();

    // Failed check returns to PLAY
    bus.submit_pulse = 1'b1;
    push("submit1", 2'd1, 0, 0, 1, 16'h0010);
    cyc(); clr_in(); check();
    push("chk_wait", 2'd1, 0, 0, 1, 16'h0010);
    cyc(); check();
    bus.chk_done = 1'b1; bus.chk_ok = 1'b0;
    push("chk_bad", 2'd1, 0, 0, 0, 16'h0010);
    cyc(); clr_in(); check();
    push("still_count", 2'd1, 0, 0, 0, 16'h0011);
    cyc(); check();

    // Successful check -> OVER with win, timer frozen
    bus.submit_pulse = 1'b1;
    push("submit2", 2'd1, 0, 0, 1, 16'h0011);
    cyc(); clr_in(); check();
    bus.chk_done = 1'b1; bus.chk_ok = 1'b1;
    push("chk_good", 2'd2, 1, 0, 0, 16'h0011);
    cyc(); clr_in(); check();
    push("over_frozen", 2'd2, 1, 0, 0, 16'h0011);
    run(8); check();
    bus.start_pulse = 1'b1;
    push("over_to_menu", 2'd0, 0, 0, 0, 16'h0011);
    cyc(); clr_in(); check();

    // Abort in CHECK together with chk_done
    bus.start_pulse = 1'b1;
    push("start2", 2'd1, 0, 1, 0, 16'h0000);
    cyc(); clr_in(); check();
    bus.init_done = 1'b1;
    cyc(); clr_in();
    run(8);
    bus.submit_pulse = 1'b1;
    push("submit3", 2'd1, 0, 0, 1, 16'h0002);
    cyc(); clr_in(); check();
    bus.abort_pulse = 1'b1; bus.chk_done = 1'b1; bus.chk_ok = 1'b1;
    push("abort_chk", 2'd0, 0, 0, 0, 16'h0000);
    cyc(); clr_in(); check();
    bus.abort_pulse = 1'b1;
    push("abort_menu", 2'd0, 0, 0, 0, 16'h0000);
    cyc(); clr_in(); check();

    // Asynchronous reset mid-PLAY at 00:37
    bus.start_pulse = 1'b1; cyc(); clr_in();
    bus.init_done = 1'b1;   cyc(); clr_in();
    push("play_37", 2'd1, 0, 0, 0, 16'h0037);
    run(148); check();
    rst_n = 1'b0;
    #2;
    push("async_rst", 2'd0, 0, 0, 0, 16'h0000);
    check();
    run(2);
    rst_n = 1'b1;
    cyc();

`ifdef GAME_TIMEOUT_EN
    // Timeout at 01:00
    bus.start_pulse = 1'b1; cyc(); clr_in();
    bus.init_done = 1'b1;   cyc(); clr_in();
    push("pre_limit", 2'd1, 0, 0, 0, 16'h0059);
    run(239); check();
    push("timeout", 2'd2, 0, 0, 0, 16'h0100);
    cyc(); check();
    bus.start_pulse = 1'b1; cyc(); clr_in();
    bus.start_pulse = 1'b1;
    push("start_to", 2'd1, 0, 1, 0, 16'h0000);
    cyc(); clr_in(); check();
    bus.init_done = 1'b1; cyc(); clr_in();
    run(237);
    bus.submit_pulse = 1'b1;
    push("submit_to", 2'd1, 0, 0, 1, 16'h0059);
    cyc(); clr_in(); check();
    cyc();
    bus.chk_done = 1'b1; bus.chk_ok = 1'b1;
    push("chk_vs_to", 2'd2, 1, 0, 0, 16'h0100);
    cyc(); clr_in(); check();
`else
    // Saturation at 99:59
    bus.start_pulse = 1'b1; cyc(); clr_in();
    bus.init_done = 1'b1;   cyc(); clr_in();
    push("reach_9959", 2'd1, 0, 0, 0, 16'h9959);
    run(23996); check();
    push("sat_hold", 2'd1, 0, 0, 0, 16'h9959);
    run(8); check();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
